// File: rtl/scan_pkg.sv
// Shared types and helpers for the pattern scan engine.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } scan_state_t;

    // Number of windows that fit entirely inside one byte.
    function automatic int in_win_count(input int pat_w);
        return 9 - pat_w;
    endfunction

    // Number of windows that begin in the previous byte and end in the current one.
    function automatic int x_win_count(input int pat_w);
        return pat_w - 1;
    endfunction

    // Adds inc to acc and clamps the result to the largest cnt_w-bit value.
    // The 32-bit sum leaves ample headroom for any counter up to 27 bits.
    function automatic logic [31:0] sat_add(input logic [31:0] acc,
                                            input logic [31:0] inc,
                                            input int          cnt_w);
        logic [31:0] limit;
        logic [31:0] sum;
        limit = (32'd1 << cnt_w) - 32'd1;
        sum   = acc + inc;
        return (sum > limit) ? limit : sum;
    endfunction

    // Largest possible in-byte match count for a scan.
    function int max_inbyte(input int pat_w, input int nbytes);
        return (9 - pat_w) * nbytes;
    endfunction

    // Largest possible matching-byte count for a scan.
    function int max_bytes(input int nbytes);
        return nbytes;
    endfunction

    // Largest possible whole-stream match count for a scan.
    function int max_stream(input int pat_w, input int nbytes);
        return 8 * nbytes - pat_w + 1;
    endfunction

endpackage

// File: rtl/window_matcher.sv
// Counts pattern hits for one byte: windows inside the byte and windows
// that straddle the boundary with the preceding byte.
module window_matcher
    import scan_pkg::*;
#(
    parameter int PAT_W = 5
) (
    input  logic [7:0]       cur,
    input  logic [PAT_W-2:0] prev_tail,
    input  logic [PAT_W-1:0] pat,
    input  logic [PAT_W-1:0] pat_mask,
    input  logic             first_byte,
    output logic [3:0]       in_hits,
    output logic [3:0]       x_hits
);

    localparam int IN_WIN = in_win_count(PAT_W);

    // Tail bits of the previous byte sit above the current byte, so stream
    // order (earliest bit first) maps onto descending bit index.
    logic [PAT_W+6:0] joined;
    assign joined = {prev_tail, cur};

    // Count masked matches among the windows wholly inside the current byte.
    always_comb begin
        in_hits = 4'd0;
        for (int k = 0; k < IN_WIN; k++) begin
            if (((cur[k +: PAT_W] ^ pat) & pat_mask) == '0) begin
                in_hits = in_hits + 4'd1;
            end
        end
    end

    // Count masked matches among the windows that start in the previous byte.
    always_comb begin
        x_hits = 4'd0;
        for (int k = IN_WIN; k < 8; k++) begin
            if (!first_byte && (((joined[k +: PAT_W] ^ pat) & pat_mask) == '0)) begin
                x_hits = x_hits + 4'd1;
            end
        end
    end

endmodule

// File: rtl/pattern_scan_unit.sv
// Scans NBYTES consecutive memory bytes for a masked bit pattern and reports
// in-byte, per-byte and whole-stream match counts through a start/done handshake.
module pattern_scan_unit
    import scan_pkg::*;
#(
    parameter int PAT_W  = 5,
    parameter int NBYTES = 32,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [PAT_W-1:0]  pat,
    input  logic [PAT_W-1:0]  pat_mask,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  cnt_inbyte,
    output logic [CNT_W-1:0]  cnt_bytes,
    output logic [CNT_W-1:0]  cnt_stream
);

    localparam int X_WIN = x_win_count(PAT_W);
    localparam int IDX_W = $clog2(NBYTES + 1);
    localparam logic [IDX_W-1:0] NB_IDX   = IDX_W'(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    scan_state_t      state;
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] mask_q;
    logic [X_WIN-1:0] prev_tail;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] cons_idx;
    logic [3:0]       in_hits;
    logic [3:0]       x_hits;
    logic             first_byte;
    logic             issue_next;

    // Byte 0 has no predecessor, so its crossing windows do not exist.
    assign first_byte = (cons_idx == '0);

    // Reads continue one per cycle after the first until every byte is requested.
    assign issue_next = ((state == FILL) || (state == SCAN)) && (rd_idx < NB_IDX);

    window_matcher #(
        .PAT_W (PAT_W)
    ) u_matcher (
        .cur        (mem_rdata),
        .prev_tail  (prev_tail),
        .pat        (pat_q),
        .pat_mask   (mask_q),
        .first_byte (first_byte),
        .in_hits    (in_hits),
        .x_hits     (x_hits)
    );

    // Control FSM, read address sequencing and saturating match counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pat_q      <= '0;
            mask_q     <= '0;
            prev_tail  <= '0;
            rd_idx     <= '0;
            cons_idx   <= '0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cnt_inbyte <= '0;
            cnt_bytes  <= '0;
            cnt_stream <= '0;
        end else begin
            mem_rd <= 1'b0;
            if (issue_next) begin
                mem_addr <= mem_addr + ADDR_W'(1);
                mem_rd   <= 1'b1;
                rd_idx   <= rd_idx + IDX_W'(1);
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        pat_q      <= pat;
                        mask_q     <= pat_mask;
                        prev_tail  <= '0;
                        cnt_inbyte <= '0;
                        cnt_bytes  <= '0;
                        cnt_stream <= '0;
                        mem_addr   <= base_addr;
                        mem_rd     <= 1'b1;
                        rd_idx     <= IDX_W'(1);
                        cons_idx   <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    state <= SCAN;
                end
                SCAN: begin
                    cnt_inbyte <= CNT_W'(sat_add(32'(cnt_inbyte), 32'(in_hits), CNT_W));
                    cnt_bytes  <= CNT_W'(sat_add(32'(cnt_bytes), {31'd0, (in_hits != 4'd0)}, CNT_W));
                    cnt_stream <= CNT_W'(sat_add(32'(cnt_stream), 32'(in_hits) + 32'(x_hits), CNT_W));
                    prev_tail  <= mem_rdata[X_WIN-1:0];
                    cons_idx   <= cons_idx + IDX_W'(1);
                    if (cons_idx == LAST_IDX) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scan_unit.sv
// Self-checking bench for pattern_scan_unit: a bit-stream reference model
// fills a scoreboard when each scan is launched, and results are compared
// when done rises.
module tb_pattern_scan_unit;
    import scan_pkg::*;

    localparam int NB_A = 32;

    typedef struct {
        int inb;
        int byt;
        int str;
    } cnt_t;

    typedef struct {
        cnt_t a;
        cnt_t c6;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a;
    logic [7:0] base_a;
    logic [4:0] pat_a;
    logic [4:0] mask_a;
    logic       start_b;
    logic [7:0] base_b;
    logic [2:0] pat_b;
    logic [2:0] mask_b;

    logic [7:0] mem_addr_a, mem_addr_c, mem_addr_b;
    logic       mem_rd_a, mem_rd_c, mem_rd_b;
    logic [7:0] rdata_a, rdata_c, rdata_b;
    logic       busy_a, busy_c, busy_b;
    logic       done_a, done_c, done_b;
    logic [7:0] cnt_inbyte_a, cnt_bytes_a, cnt_stream_a;
    logic [5:0] cnt_inbyte_c, cnt_bytes_c, cnt_stream_c;
    logic [7:0] cnt_inbyte_b, cnt_bytes_b, cnt_stream_b;

    logic [7:0] mem [256];
    exp_t       exp_q[$];
    logic [7:0] addr_q[$];
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    // Synchronous memory: data appears one cycle after the address.
    always @(posedge clk) begin
        rdata_a <= mem[mem_addr_a];
        rdata_c <= mem[mem_addr_c];
        rdata_b <= mem[mem_addr_b];
    end

    pattern_scan_unit #(.PAT_W(5), .NBYTES(32), .ADDR_W(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start_a), .base_addr(base_a),
        .pat(pat_a), .pat_mask(mask_a), .mem_addr(mem_addr_a), .mem_rd(mem_rd_a),
        .mem_rdata(rdata_a), .busy(busy_a), .done(done_a),
        .cnt_inbyte(cnt_inbyte_a), .cnt_bytes(cnt_bytes_a), .cnt_stream(cnt_stream_a)
    );

    pattern_scan_unit #(.PAT_W(5), .NBYTES(32), .ADDR_W(8), .CNT_W(6)) dut_c6 (
        .clk(clk), .reset(reset), .start(start_a), .base_addr(base_a),
        .pat(pat_a), .pat_mask(mask_a), .mem_addr(mem_addr_c), .mem_rd(mem_rd_c),
        .mem_rdata(rdata_c), .busy(busy_c), .done(done_c),
        .cnt_inbyte(cnt_inbyte_c), .cnt_bytes(cnt_bytes_c), .cnt_stream(cnt_stream_c)
    );

    pattern_scan_unit #(.PAT_W(3), .NBYTES(4), .ADDR_W(8), .CNT_W(8)) dut_p3 (
        .clk(clk), .reset(reset), .start(start_b), .base_addr(base_b),
        .pat(pat_b), .pat_mask(mask_b), .mem_addr(mem_addr_b), .mem_rd(mem_rd_b),
        .mem_rdata(rdata_b), .busy(busy_b), .done(done_b),
        .cnt_inbyte(cnt_inbyte_b), .cnt_bytes(cnt_bytes_b), .cnt_stream(cnt_stream_b)
    );

    // Every read strobe of the main instance must match the next expected address.
    always @(negedge clk) begin
        logic [7:0] want;
        if (reset === 1'b1 && mem_rd_a === 1'b1) begin
            checks++;
            if (addr_q.size() == 0) begin
                failures++;
                $error("FAIL unexpected_read observed=%0d expected=none", mem_addr_a);
            end else begin
                want = addr_q.pop_front();
                assert (mem_addr_a === want) else begin
                    failures++;
                    $error("FAIL read_addr observed=%0d expected=%0d", mem_addr_a, want);
                end
            end
        end
    end

    function automatic int clamp_cnt(input int v, input int cw);
        int lim;
        lim = (1 << cw) - 1;
        return (v > lim) ? lim : v;
    endfunction

    // Reference: lay the bytes out as a bit stream and test every window.
    function automatic cnt_t model(input int pw, input int nb, input int base,
                                   input int p, input int m, input int cw);
        bit         bits [256];
        int         per [32];
        cnt_t       r;
        int         total;
        int         w;
        logic [7:0] v;
        r = '{0, 0, 0};
        for (int b = 0; b < nb; b++) begin
            v = mem[(base + b) % 256];
            per[b] = 0;
            for (int j = 0; j < 8; j++) bits[8*b + j] = v[7-j];
        end
        total = 8*nb - pw + 1;
        for (int i = 0; i < total; i++) begin
            w = 0;
            for (int j = 0; j < pw; j++) w = (w << 1) | int'(bits[i+j]);
            if (((w ^ p) & m) == 0) begin
                r.str++;
                if ((i / 8) == ((i + pw - 1) / 8)) begin
                    r.inb++;
                    per[i/8]++;
                end
            end
        end
        for (int b = 0; b < nb; b++) if (per[b] > 0) r.byt++;
        r.inb = clamp_cnt(r.inb, cw);
        r.byt = clamp_cnt(r.byt, cw);
        r.str = clamp_cnt(r.str, cw);
        return r;
    endfunction

    function automatic exp_t expect_for(input int base, input int p, input int m);
        exp_t e;
        e.a  = model(5, NB_A, base, p, m, 8);
        e.c6 = model(5, NB_A, base, p, m, 6);
        return e;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic fill_all(input logic [7:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_inbyte"}, cnt_inbyte_a, 0);
        check_val({tag, "_bytes"},  cnt_bytes_a,  0);
        check_val({tag, "_stream"}, cnt_stream_a, 0);
        check_val({tag, "_busy"},   busy_a,       0);
        check_val({tag, "_done"},   done_a,       0);
        check_val({tag, "_mem_rd"}, mem_rd_a,     0);
        check_val({tag, "_addr"},   mem_addr_a,   0);
    endtask

    // Launch a scan on the main instances and record what it should produce.
    task automatic apply_stimulus(input int base, input int p, input int m, input exp_t e);
        @(negedge clk);
        base_a  = 8'(base);
        pat_a   = 5'(p);
        mask_a  = 5'(m);
        start_a = 1'b1;
        exp_q.push_back(e);
        for (int i = 0; i < NB_A; i++) addr_q.push_back(8'(base + i));
    endtask

    // Wait for done, optionally pulsing start again mid-scan, then score the result.
    task automatic check_output(input int extra_at);
        int   lat;
        bit   seen;
        exp_t e;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 1) begin
                start_a = 1'b0;
                check_val("busy_after_start", busy_a, 1);
                check_val("done_after_start", done_a, 0);
            end
            if (lat == extra_at) start_a = 1'b1;
            else if (lat == extra_at + 1) start_a = 1'b0;
            if (done_a === 1'b1) seen = 1'b1;
        end
        check_val("done_seen", seen, 1);
        check_val("latency", lat, NB_A + 2);
        check_val("done_c6", done_c, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("cnt_inbyte", cnt_inbyte_a, e.a.inb);
            check_val("cnt_bytes",  cnt_bytes_a,  e.a.byt);
            check_val("cnt_stream", cnt_stream_a, e.a.str);
            check_val("c6_inbyte",  cnt_inbyte_c, e.c6.inb);
            check_val("c6_bytes",   cnt_bytes_c,  e.c6.byt);
            check_val("c6_stream",  cnt_stream_c, e.c6.str);
            @(posedge clk);
            #1;
            check_val("done_hold",   done_a,       1);
            check_val("stream_hold", cnt_stream_a, e.a.str);
        end else begin
            check_val("scoreboard_entry", 0, 1);
        end
    endtask

    initial begin
        exp_t e;
        cnt_t eb;
        int   lat;
        bit   seen;

        reset   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        base_a  = '0;
        pat_a   = '0;
        mask_a  = '0;
        base_b  = '0;
        pat_b   = '0;
        mask_b  = '0;
        fill_all(8'h00);

        repeat (2) @(negedge clk);
        check_zero("reset");
        reset = 1'b1;

        $display("[TB] alternating pattern over 0x55");
        fill_all(8'h55);
        apply_stimulus(0, 5'b10101, 5'b11111, expect_for(0, 5'b10101, 5'b11111));
        check_output(-1);

        $display("[TB] all-zero pattern and data, saturation on narrow counters");
        fill_all(8'h00);
        apply_stimulus(0, 5'b00000, 5'b11111, expect_for(0, 5'b00000, 5'b11111));
        check_output(-1);

        $display("[TB] crossing-only match");
        fill_all(8'h00);
        mem[0] = 8'h07;
        mem[1] = 8'hC0;
        apply_stimulus(0, 5'b11111, 5'b11111, expect_for(0, 5'b11111, 5'b11111));
        check_output(-1);
        fill_all(8'h00);
        apply_stimulus(0, 5'b11111, 5'b11111, expect_for(0, 5'b11111, 5'b11111));
        check_output(-1);

        $display("[TB] full don't-care mask");
        fill_all(8'h55);
        e.a  = '{clamp_cnt(max_inbyte(5, NB_A), 8), clamp_cnt(max_bytes(NB_A), 8),
                 clamp_cnt(max_stream(5, NB_A), 8)};
        e.c6 = '{clamp_cnt(max_inbyte(5, NB_A), 6), clamp_cnt(max_bytes(NB_A), 6),
                 clamp_cnt(max_stream(5, NB_A), 6)};
        apply_stimulus(0, 5'b10101, 5'b00000, e);
        check_output(-1);

        $display("[TB] address wrap from 240");
        fill_all(8'h00);
        apply_stimulus(240, 5'b00000, 5'b11111, expect_for(240, 5'b00000, 5'b11111));
        check_output(-1);

        $display("[TB] second start during scan is ignored");
        fill_all(8'h55);
        apply_stimulus(0, 5'b10101, 5'b11111, expect_for(0, 5'b10101, 5'b11111));
        check_output(10);

        $display("[TB] start while done restarts at once");
        apply_stimulus(0, 5'b00000, 5'b00000, expect_for(0, 5'b00000, 5'b00000));
        check_output(-1);

        $display("[TB] reset in the middle of a scan");
        apply_stimulus(0, 5'b10101, 5'b11111, expect_for(0, 5'b10101, 5'b11111));
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_zero("mid_reset");
        exp_q.delete();
        addr_q.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_val("idle_busy",   busy_a,   0);
        check_val("idle_done",   done_a,   0);
        check_val("idle_mem_rd", mem_rd_a, 0);
        apply_stimulus(0, 5'b10101, 5'b11111, expect_for(0, 5'b10101, 5'b11111));
        check_output(-1);

        $display("[TB] 3-bit pattern over four bytes");
        fill_all(8'h00);
        for (int i = 16; i < 20; i++) mem[i] = 8'h55;
        eb = model(3, 4, 16, 3'b101, 3'b111, 8);
        @(negedge clk);
        base_b  = 8'd16;
        pat_b   = 3'b101;
        mask_b  = 3'b111;
        start_b = 1'b1;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 50) begin
            @(posedge clk);
            lat++;
            #1;
            start_b = 1'b0;
            if (done_b === 1'b1) seen = 1'b1;
        end
        check_val("p3_done_seen", seen, 1);
        check_val("p3_latency", lat, 4 + 2);
        check_val("p3_inbyte",  cnt_inbyte_b, eb.inb);
        check_val("p3_bytes",   cnt_bytes_b,  eb.byt);
        check_val("p3_stream",  cnt_stream_b, eb.str);

        repeat (2) @(negedge clk);
        check_val("reads_left",   addr_q.size(), 0);
        check_val("results_left", exp_q.size(),  0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
